// File: rtl/encode_acc_requant.sv
// Saturating accumulator for signed multiplier products. On the last beat of a dot
// product it rounds half-up, shifts, clips to OUT_WIDTH and presents the result on a valid/ready register.
module encode_acc_requant #(
  parameter int IN_WIDTH  = 68,
  parameter int ACC_WIDTH = 76,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 28
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_sat
);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    ROUND = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  // Requant bounds and rounding constant live at ACC_WIDTH+1 bits.
  localparam logic signed [ACC_WIDTH:0] OUT_MAX =
    {{(ACC_WIDTH+2-OUT_WIDTH){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] OUT_MIN =
    {{(ACC_WIDTH+2-OUT_WIDTH){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH:0] RND = (SHIFT == 0) ? '0 :
    ({{ACC_WIDTH{1'b0}}, 1'b1} << ((SHIFT > 0) ? SHIFT - 1 : 0));

  state_t state, state_next;

  logic signed [ACC_WIDTH-1:0] acc;
  logic                        sat_flag;

  logic signed [ACC_WIDTH:0]   acc_ext;
  logic signed [ACC_WIDTH:0]   in_ext;
  logic signed [ACC_WIDTH:0]   acc_sum;
  logic                        add_ovf;
  logic signed [ACC_WIDTH-1:0] acc_add;

  logic signed [ACC_WIDTH:0]   rounded;
  logic signed [ACC_WIDTH:0]   shifted;
  logic [OUT_WIDTH-1:0]        res_data;
  logic                        res_clip;

  // ---------------------------------------------------------------------------
  // Saturating accumulate: one guard bit exposes overflow as a sign mismatch.
  // ---------------------------------------------------------------------------
  always_comb begin
    acc_ext = {acc[ACC_WIDTH-1], acc};
    in_ext  = {{(ACC_WIDTH+1-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};
    acc_sum = acc_ext + in_ext;
    add_ovf = acc_sum[ACC_WIDTH] ^ acc_sum[ACC_WIDTH-1];
    if (!add_ovf)
      acc_add = acc_sum[ACC_WIDTH-1:0];
    else if (acc_sum[ACC_WIDTH])
      acc_add = ACC_MIN;
    else
      acc_add = ACC_MAX;
  end

  // Round half-up, arithmetic shift, clip to the output range.
  always_comb begin
    rounded  = acc_ext + RND;
    shifted  = rounded >>> SHIFT;
    res_clip = 1'b0;
    res_data = shifted[OUT_WIDTH-1:0];
    if (shifted > OUT_MAX) begin
      res_data = OUT_MAX[OUT_WIDTH-1:0];
      res_clip = 1'b1;
    end else if (shifted < OUT_MIN) begin
      res_data = OUT_MIN[OUT_WIDTH-1:0];
      res_clip = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset_n)
      state <= ACCUM;
    else
      state <= state_next;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && in_last)
          state_next = ROUND;
      end
      ROUND: state_next = HOLD;
      HOLD: begin
        if (out_ready)
          state_next = ACCUM;
      end
      default: state_next = ACCUM;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc       <= '0;
      sat_flag  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid) begin
            acc <= acc_add;
            if (add_ovf)
              sat_flag <= 1'b1;
          end
        end
        ROUND: begin
          out_data  <= res_data;
          out_sat   <= sat_flag | res_clip;
          out_valid <= 1'b1;
          acc       <= '0;
          sat_flag  <= 1'b0;
        end
        HOLD: begin
          if (out_ready)
            out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_encode_acc_requant.sv
// Directed bench for encode_acc_requant: rounding, clipping, accumulator clamp,
// output back-pressure and asynchronous reset in HOLD.
module tb_encode_acc_requant;

  localparam int IN_WIDTH  = 68;
  localparam int ACC_WIDTH = 76;
  localparam int OUT_WIDTH = 16;
  localparam int SHIFT     = 28;

  logic                        clk;
  logic                        reset_n;
  logic                        in_valid;
  logic                        in_ready;
  logic signed [IN_WIDTH-1:0]  in_data;
  logic                        in_last;
  logic                        out_valid;
  logic                        out_ready;
  logic        [OUT_WIDTH-1:0] out_data;
  logic                        out_sat;

  int tests_run;
  int tests_failed;

  logic signed [IN_WIDTH-1:0] in_max;
  logic signed [IN_WIDTH-1:0] in_min;
  logic signed [IN_WIDTH-1:0] one_q;
  logic        [OUT_WIDTH-1:0] held_data;
  logic                        held_sat;

  encode_acc_requant #(
    .IN_WIDTH (IN_WIDTH),
    .ACC_WIDTH(ACC_WIDTH),
    .OUT_WIDTH(OUT_WIDTH),
    .SHIFT    (SHIFT)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sat  (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive n consecutive beats of value d; in_last on the final one if last=1.
  // Returns #1 after the edge that accepted the final beat.
  task automatic send_burst(input logic signed [IN_WIDTH-1:0] d, input int n,
                            input logic last);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last && (i == n - 1);
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called #1 after the last beat was accepted: checks ROUND, latency, result,
  // then completes the output handshake and checks the return to ACCUM.
  task automatic expect_result(input string tag, input longint exp_data,
                               input logic exp_sat);
    check({tag, ".round_valid"}, out_valid, 0);
    check({tag, ".round_ready"}, in_ready, 0);
    @(posedge clk); #1;
    check({tag, ".valid"}, out_valid, 1);
    check({tag, ".data"}, $signed(out_data), exp_data);
    check({tag, ".sat"}, out_sat, exp_sat);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".drop_valid"}, out_valid, 0);
    check({tag, ".in_ready"}, in_ready, 1);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    in_max    = {1'b0, {(IN_WIDTH-1){1'b1}}};
    in_min    = {1'b1, {(IN_WIDTH-1){1'b0}}};
    one_q     = 68'sd268435456;

    #12;
    check("rst.out_valid", out_valid, 0);
    check("rst.in_ready", in_ready, 1);
    check("rst.out_data", $signed(out_data), 0);
    check("rst.out_sat", out_sat, 0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(2);

    // 1.5 -> rounds to 2; -1.5 -> rounds half up to -1
    send_burst(68'sd402653184, 1, 1'b1);
    expect_result("pos_half", 2, 1'b0);
    send_burst(-68'sd402653184, 1, 1'b1);
    expect_result("neg_half", -1, 1'b0);

    // Four 1.0 beats with gaps, then the accumulator restarts from zero
    send_burst(one_q, 1, 1'b0); idle(2);
    send_burst(one_q, 1, 1'b0); idle(1);
    send_burst(one_q, 1, 1'b0); idle(3);
    send_burst(one_q, 1, 1'b1);
    expect_result("gapped4", 4, 1'b0);
    send_burst(one_q, 1, 1'b1);
    expect_result("after_clear", 1, 1'b0);

    // Output clipping without accumulator overflow
    send_burst(68'sd1 <<< 60, 1, 1'b1);
    expect_result("clip_hi", 32767, 1'b1);
    send_burst(-(68'sd1 <<< 60), 1, 1'b1);
    expect_result("clip_lo", -32768, 1'b1);

    // 256 x (2^67-1) = 2^75-256: result clips high
    send_burst(in_max, 256, 1'b1);
    expect_result("burst256", 32767, 1'b1);

    // 257 x (2^67-1) overflows and clamps at 2^75-1; 256 x -2^67 then brings
    // the clamped sum to -1, which rounds to 0. Sticky flag keeps out_sat=1.
    send_burst(in_max, 257, 1'b0);
    send_burst(in_min, 256, 1'b1);
    expect_result("acc_clamp", 0, 1'b1);

    // Back-pressure: result and in_ready hold while out_ready=0
    send_burst(68'sd805306368, 1, 1'b1);
    @(posedge clk); #1;
    check("hold.valid0", out_valid, 1);
    check("hold.data0", $signed(out_data), 3);
    held_data = out_data;
    held_sat  = out_sat;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold.valid", out_valid, 1);
      check("hold.data", $signed(out_data), $signed(held_data));
      check("hold.sat", out_sat, held_sat);
      check("hold.in_ready", in_ready, 0);
    end

    // Asynchronous reset during HOLD takes effect without a clock edge
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("areset.out_valid", out_valid, 0);
    check("areset.in_ready", in_ready, 1);
    check("areset.out_data", $signed(out_data), 0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(1);

    // Partial sum discarded by reset
    send_burst(one_q, 2, 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    idle(1);
    send_burst(one_q, 1, 1'b1);
    expect_result("partial_reset", 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
